// File: rtl/register_scoreboard_file.sv
// Register file with a per-register pending-write scoreboard for in-order issue.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module register_scoreboard_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [WIDTH-1:0]  data_a,
    output logic [WIDTH-1:0]  data_b,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_pending_cnt;

    logic w_wr_en;
    logic w_rsv_en;
    logic w_set_new;
    logic w_clr_busy;

    assign w_wr_en   = write   && (addr_in      != '0);
    assign w_rsv_en  = reserve && (reserve_addr != '0);
    assign w_set_new = w_rsv_en && !r_busy[reserve_addr];
    // A reservation to the register being written keeps it busy for the newer producer.
    assign w_clr_busy = w_wr_en && r_busy[addr_in] &&
                        !(w_rsv_en && (reserve_addr == addr_in));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_busy        <= '0;
            r_pending_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[addr_in] <= data_in;
                r_busy[addr_in] <= 1'b0;
            end
            if (w_rsv_en) r_busy[reserve_addr] <= 1'b1;
            case ({w_set_new, w_clr_busy})
                2'b10:   r_pending_cnt <= r_pending_cnt + CNT_ONE;
                2'b01:   r_pending_cnt <= r_pending_cnt - CNT_ONE;
                default: r_pending_cnt <= r_pending_cnt;
            endcase
        end
    end

    always_comb begin
        data_a = (addr_a == '0) ? '0 : r_regs[addr_a];
        data_b = (addr_b == '0) ? '0 : r_regs[addr_b];
        busy_a = (addr_a != '0) && r_busy[addr_a];
        busy_b = (addr_b != '0) && r_busy[addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (addr_in == addr_a)) begin
            data_a = data_in;
            busy_a = 1'b0;
        end
        if (w_wr_en && (addr_in == addr_b)) begin
            data_b = data_in;
            busy_b = 1'b0;
        end
`endif
    end

    assign stall       = busy_a || busy_b;
    assign pending_cnt = r_pending_cnt;
endmodule
